// File: rtl/aes_pkg.sv
// Shared AES constants and types: round-key/step counts, Rcon table,
// round-key and cipher-key typedefs, key-schedule FSM state encoding.
package aes_pkg;

    localparam int AES_NRK   = 15;
    localparam int AES_NSTEP = 7;

    typedef logic [127:0] rk_t;
    typedef logic [255:0] key256_t;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_READY  = 2'd2
    } ks_state_e;

    localparam logic [7:0] AES_RCON [0:AES_NSTEP-1] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    function automatic logic [7:0] aes_rcon(input logic [2:0] k);
        logic [7:0] rc;
        rc = 8'h00;
        for (int i = 0; i < AES_NSTEP; i++) begin
            if (k == 3'(i)) rc = AES_RCON[i];
        end
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero for free
    always_comb begin
        sq  = in_byte;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/aes256_key_schedule.sv
// Iterative AES-256 key schedule: one 256-bit expansion step per cycle into a
// 15-entry round-key file. AES_KS_DEC_ORDER_EN selects decryption-order reads.
//   state     | meaning
//   KS_IDLE   | after reset, no valid keys
//   KS_EXPAND | step cnt 0..6 in progress
//   KS_READY  | all 15 round keys valid and stable
module aes256_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    output logic         busy,
    output logic         ready,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    ks_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    key256_t    w_q, w_d;
    rk_t        rk_q [0:AES_NRK-1];
    rk_t        rk_d [0:AES_NRK-1];
    rk_t        rd_key_q, rd_key_d;

    logic       last_step;
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
    logic [31:0] rot_w7, sub_rot, sub_n3, t;
    logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
    logic [3:0]  sel;

    assign {w0, w1, w2, w3, w4, w5, w6, w7} = w_q;
    assign rot_w7    = {w7[23:0], w7[31:24]};
    assign last_step = (cnt_q == 3'(AES_NSTEP - 1));

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox_rot (.in_byte(rot_w7[8*g +: 8]), .out_byte(sub_rot[8*g +: 8]));
        aes_sbox u_sbox_sub (.in_byte(n3[8*g +: 8]),     .out_byte(sub_n3[8*g +: 8]));
    end

    always_comb begin
        t  = sub_rot ^ {aes_rcon(cnt_q), 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        n4 = w4 ^ sub_n3;
        n5 = w5 ^ n4;
        n6 = w6 ^ n5;
        n7 = w7 ^ n6;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= KS_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            KS_IDLE, KS_READY: if (start) state_d = KS_EXPAND;
            KS_EXPAND:         if (last_step) state_d = KS_READY;
            default:           state_d = KS_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == KS_EXPAND);
        ready = (state_q == KS_READY);
    end

    always_comb begin
        cnt_d = cnt_q;
        w_d   = w_q;
        rk_d  = rk_q;
        if (start && (state_q != KS_EXPAND)) begin
            rk_d[0] = key[255:128];
            rk_d[1] = key[127:0];
            w_d     = key;
            cnt_d   = 3'd0;
        end else if (state_q == KS_EXPAND) begin
            rk_d[{cnt_q, 1'b0} + 4'd2] = {n0, n1, n2, n3};
            // the final step's upper half would be round key 15, which AES-256 never uses
            if (!last_step) rk_d[{cnt_q, 1'b0} + 4'd3] = {n4, n5, n6, n7};
            w_d   = {n0, n1, n2, n3, n4, n5, n6, n7};
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_comb begin
`ifdef AES_KS_DEC_ORDER_EN
        sel = 4'd14 - rd_idx;
`else
        sel = rd_idx;
`endif
        rd_key_d = '0;
        if (rd_idx <= 4'd14) rd_key_d = rk_q[sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 3'd0;
            w_q      <= '0;
            rd_key_q <= '0;
            for (int i = 0; i < AES_NRK; i++) rk_q[i] <= '0;
        end else begin
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            rd_key_q <= rd_key_d;
            for (int i = 0; i < AES_NRK; i++) rk_q[i] <= rk_d[i];
        end
    end

    assign rd_key = rd_key_q;

endmodule

// File: tb/tb_aes256_key_schedule.sv
// Self-checking bench for aes256_key_schedule against a word-oriented
// FIPS-197 key-expansion model; honours AES_KS_DEC_ORDER_EN.
module tb_aes256_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] key;
    logic         busy;
    logic         ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]   sbox   [256];
    logic [127:0] exp_rk [15];

    localparam logic [255:0] FIPS_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    always #5 clk = ~clk;

    aes256_key_schedule dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .key    (key),
        .busy   (busy),
        .ready  (ready),
        .rd_idx (rd_idx),
        .rd_key (rd_key)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc = 8'h00;
        logic [7:0] x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return acc;
    endfunction

    // S-box from brute-force inverse search plus the bitwise affine definition
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 1'b1);
            sbox[x] = s;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] v);
        return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
    endfunction

    task automatic expand_model(input logic [255:0] k);
        logic [31:0] wd [60];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 8; i++) wd[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = wd[i-1];
            if (i % 8 == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = subword(tmp);
            end
            wd[i] = wd[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
    endtask

    // involution between round-key number and port index
    function automatic logic [3:0] port_idx(input int r);
`ifdef AES_KS_DEC_ORDER_EN
        return 4'(14 - r);
`else
        return 4'(r);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [255:0] k);
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
        key   = {8{$urandom()}};
    endtask

    // start, then exact busy/ready cycle profile; optional ignored start mid-expansion
    task automatic run_timed(input logic [255:0] k, input bit poke, input string tag);
        pulse_start(k);
        check({tag, "_busy0"}, {busy, ready}, 2'b10);
        for (int c = 1; c < 7; c++) begin
            if (poke && c == 3) begin
                key   = ~k;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            check({tag, "_busy"}, {busy, ready}, 2'b10);
        end
        tick();
        check({tag, "_ready"}, {busy, ready}, 2'b01);
    endtask

    task automatic wait_ready(input string tag);
        for (int c = 0; c < 20 && !ready; c++) tick();
        check({tag, "_ready_wait"}, ready, 1'b1);
    endtask

    task automatic read_sweep(input string tag);
        rd_idx = 4'd0;
        for (int p = 0; p < 15; p++) begin
            tick();
            rd_idx = 4'(p + 1);
            #1;
            check($sformatf("%s_rd%0d", tag, p), rd_key, exp_rk[port_idx(p)]);
        end
        tick();
        check({tag, "_rd_range"}, rd_key, 128'h0);
    endtask

    task automatic read_one(input int r, input logic [127:0] exp, input string tag);
        rd_idx = port_idx(r);
        tick();
        check(tag, rd_key, exp);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        key    = '0;
        rd_idx = 4'd0;
        build_sbox();
        repeat (3) tick();
        check("reset_flags", {busy, ready}, 2'b00);
        check("reset_rd_key", rd_key, 128'h0);

        // reset wins over a simultaneous start
        start = 1'b1;
        key   = FIPS_KEY;
        tick();
        check("rst_start_busy", busy, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("idle_flags", {busy, ready}, 2'b00);

        run_timed(FIPS_KEY, 1'b1, "fips");
        repeat (2) tick();
        check("fips_ready_hold", {busy, ready}, 2'b01);
        read_one(0,  128'h000102030405060708090a0b0c0d0e0f, "fips_rk0");
        read_one(1,  128'h101112131415161718191a1b1c1d1e1f, "fips_rk1");
        read_one(2,  128'ha573c29fa176c498a97fce93a572c09c, "fips_rk2");
        read_one(14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "fips_rk14");
        rd_idx = 4'd0;
        tick();
`ifdef AES_KS_DEC_ORDER_EN
        check("fips_dec_idx0", rd_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
`else
        check("fips_enc_idx0", rd_key, 128'h000102030405060708090a0b0c0d0e0f);
`endif
        expand_model(FIPS_KEY);
        read_sweep("fips");

        run_timed({256{1'b1}}, 1'b0, "ones");
        expand_model({256{1'b1}});
        read_sweep("ones");

        // reset while cnt = 3
        pulse_start({8{$urandom()}});
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_flags", {busy, ready}, 2'b00);
        check("midrst_rd_key", rd_key, 128'h0);
        begin
            logic [255:0] k2 = {8{$urandom()}};
            run_timed(k2, 1'b0, "postrst");
            expand_model(k2);
            read_sweep("postrst");
        end

        for (int n = 0; n < 1000; n++) begin
            logic [255:0] kr = {$urandom(), $urandom(), $urandom(), $urandom(),
                                $urandom(), $urandom(), $urandom(), $urandom()};
            pulse_start(kr);
            wait_ready($sformatf("rand%0d", n));
            expand_model(kr);
            read_sweep($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes256_key_schedule.md
# aes256_key_schedule

Iterative AES-256 key-schedule unit feeding the decipher datapath. It accepts a 256-bit cipher key on a start pulse and expands it one 256-bit step per cycle. The 15 round keys are held in an internal register file, and the decipher reads back one 128-bit round key per cycle by index. This replaces the seven-deep combinational expansion chain with a 7-cycle sequential engine and stored keys.

## Interface
- Parameters: none. Round-key count (15), step count (7) and Rcon table are package constants.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  load `key` and begin expansion. Accepted in IDLE or READY only.
- key  in  256  cipher key; `key[255:128]` is round key 0. Sampled only on an accepted start.
- busy  out  1  expansion in progress.
- ready  out  1  all 15 round keys valid.
- rd_idx  in  4  round-key index, 0..14.
- rd_key  out  128  registered round-key read data.

## Operation
- FSM states:
  - IDLE: after reset.
  - EXPAND: step counter `cnt` runs 0..6.
  - READY.
- Accepted start:
  - `rk[0] <= key[255:128]`, `rk[1] <= key[127:0]`.
  - Working register `w <= key`, `cnt <= 0`, go to EXPAND.
- EXPAND step `cnt = k`, computed from `w` = words w0..w7, MSW first:
  - `t = SubWord(RotWord(w7)) ^ {Rcon[k], 24'h0}`, with Rcon = 01, 02, 04, 08, 10, 20, 40.
  - `n0 = w0^t`, `n1 = w1^n0`, `n2 = w2^n1`, `n3 = w3^n2`.
  - `u = SubWord(n3)`; `n4 = w4^u`, `n5 = w5^n4`, `n6 = w6^n5`, `n7 = w7^n6`.
  - Write `rk[2k+2] <= {n0..n3}`.
  - For k < 6, also write `rk[2k+3] <= {n4..n7}`. For k = 6, the upper half is discarded.
  - `w <= {n0..n7}`, `cnt <= cnt+1`.
  - When k = 6, go to READY.
- READY: the register file is held stable. A new start restarts the sequence; `ready` drops the next cycle.
- Start during EXPAND is ignored. There is no queueing and no abort.
- Read port:
  - `rd_key <=` selected round key every cycle, regardless of state.
  - `rd_idx` > 14 gives `rd_key = 0`.
  - Data read while not `ready` is undefined-by-contract: it is the current register content, and the bench must not check it.
- Reset:
  - State becomes IDLE; `cnt`, `w` and all `rk` are zeroed.
  - `busy = 0`, `ready = 0`, `rd_key = 0`.
  - Reset mid-EXPAND discards the partial schedule.

## Timing
- Start accepted at edge T: `busy = 1` after T through edge T+7; `ready = 1` after edge T+7. Key-to-ready is 7 cycles after the start cycle.
- `busy` and `ready` are never high together. Both are low in IDLE.
- Read latency is 1 cycle: `rd_idx` presented before edge N gives `rd_key` after edge N. Back-to-back reads are allowed every cycle.
- Start with rst high in the same cycle: reset wins.
- Per-cycle critical path: 8 S-box lookups plus the XOR chain of one step. No other combinational path is allowed from key to outputs.

## Configuration
- `AES_KS_DEC_ORDER_EN`
  - Defined: the read port is indexed in decryption order. `rd_idx = i` returns `rk[14-i]`, so index 0 is the first key the decipher applies.
  - Undefined: `rd_idx = i` returns `rk[i]` (encryption order).
- Range check (> 14 gives 0) and latency are identical in both builds.

## Structure
- Shared package `aes_pkg`:
  - constants `AES_NRK = 15`, `AES_NSTEP = 7`;
  - Rcon table;
  - `rk_t` (128-bit) and `key256_t` typedefs;
  - FSM state enum.
- One sub-module, `aes_sbox` (combinational byte substitution).
  - 8 instances: 4 for the RotWord path and 4 for the SubWord(n3) path.
  - Reusable by the round logic.

## Test plan
- FIPS-197 C.3 key 000102…1f, encryption order: after `ready`, rd_idx 0, 1, 2, 14 give 00010203…0c0d0e0f, 101112…1e1f, a573c29fa176c498a97fce93a572c09c, 24fc79ccbf0979e9371ac23c6d68de36.
- Handshake timing: start for 1 cycle → `busy` high for exactly 7 cycles, `ready` rises on the 8th edge and stays high. A second start during `busy` has no effect on the results.
- Restart from READY with key all-ff: `ready` drops next cycle, returns 7 cycles later, and every `rk` matches the reference model for the new key.
- Reset asserted at cnt = 3: next cycle `busy = 0`, `ready = 0`, `rd_key = 0`. A fresh start then completes correctly.
- Read port: rd_idx 15 → 0; sweeping indices 0..14 on consecutive cycles returns each key with 1-cycle latency. With `AES_KS_DEC_ORDER_EN`, index 0 gives 24fc79cc…6d68de36.
- Random keys (≥1000) against the software key-expansion model in both macro builds.
